mem_port_arbiter: RTL and testbench

//  Shares one single-ported instruction/data word memory between the pipeline fetch port (IF, read-only) and the data port (MEM stage, LW/SW).

---
 rtl/mem_port_arbiter.sv | 168 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported word memory between the fetch port and the data port.
// Each access runs IDLE -> ISSUE -> WAIT -> ACK; out-of-range addresses go straight to ACK.
module mem_port_arbiter #(
  parameter int unsigned DW              = 32,
  parameter int unsigned AW              = 10,
  parameter int unsigned MEM_DEPTH       = 1024,
  parameter int unsigned MEM_LAT         = 1,
  parameter int unsigned MAX_DATA_STREAK = 4
) (
  input  logic          clk1,
  input  logic          reset_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  input  logic          if_flush,
  output logic          if_ack,
  output logic [DW-1:0] if_rdata,
  output logic          if_err,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic          d_err,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam int unsigned CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int unsigned SW = $clog2(MAX_DATA_STREAK + 1);
  localparam logic [CW-1:0] LastWait  = CW'(MEM_LAT - 1);
  localparam logic [SW-1:0] StreakMax = SW'(MAX_DATA_STREAK);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StAck} state_e;

  state_e        state_q, state_d;
  logic          owner_q, owner_d;  // 1 = fetch port owns the access, 0 = data port
  logic [SW-1:0] streak_q, streak_d;
  logic          drop_q, drop_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic          if_err_q, if_err_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          d_err_q, d_err_d;
  logic          grant_if;
  logic [AW-1:0] sel_addr;
  logic          sel_err;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    streak_d   = streak_q;
    drop_d     = drop_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    cnt_d      = cnt_q;
    if_rdata_d = if_rdata_q;
    if_err_d   = if_err_q;
    d_rdata_d  = d_rdata_q;
    d_err_d    = d_err_q;
    grant_if   = 1'b0;
    sel_addr   = '0;
    sel_err    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (if_req || d_req) begin
          // Data wins unless the fetch port has already waited out a full streak.
          grant_if = if_req && (!d_req || streak_q == StreakMax);
          sel_addr = grant_if ? if_addr : d_addr;
          sel_err  = 32'(sel_addr) >= MEM_DEPTH;
          owner_d  = grant_if;
          streak_d = (!grant_if && if_req) ? streak_q + 1'b1 : '0;
          addr_d   = sel_addr;
          we_d     = !grant_if && d_we;
          wdata_d  = (!grant_if && d_we) ? d_wdata : '0;
          if (sel_err) begin
            state_d = StAck;
            if (grant_if) begin
              if_rdata_d = '0;
              if_err_d   = 1'b1;
            end else begin
              d_rdata_d = '0;
              d_err_d   = 1'b1;
            end
          end else begin
            state_d = StIssue;
          end
        end
      end
      StIssue: begin
        state_d = StWait;
        cnt_d   = '0;
        if (owner_q && if_flush) drop_d = 1'b1;
      end
      StWait: begin
        if (owner_q && if_flush) drop_d = 1'b1;
        if (cnt_q == LastWait) begin
          state_d = StAck;
          if (!owner_q) begin
            d_rdata_d = we_q ? '0 : mem_rdata;
            d_err_d   = 1'b0;
          end else if (!drop_d) begin
            if_rdata_d = mem_rdata;
            if_err_d   = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StAck: begin
        state_d = StIdle;
        drop_d  = 1'b0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk1 or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      owner_q    <= 1'b0;
      streak_q   <= '0;
      drop_q     <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      cnt_q      <= '0;
      if_rdata_q <= '0;
      if_err_q   <= 1'b0;
      d_rdata_q  <= '0;
      d_err_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      streak_q   <= streak_d;
      drop_q     <= drop_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      cnt_q      <= cnt_d;
      if_rdata_q <= if_rdata_d;
      if_err_q   <= if_err_d;
      d_rdata_q  <= d_rdata_d;
      d_err_q    <= d_err_d;
    end
  end

  assign busy      = state_q != StIdle;
  assign mem_en    = state_q == StIssue;
  assign mem_we    = mem_en && we_q;
  assign mem_addr  = mem_en ? addr_q : '0;
  assign mem_wdata = mem_en ? wdata_q : '0;
  assign if_ack    = (state_q == StAck) && owner_q && !drop_q;
  assign d_ack     = (state_q == StAck) && !owner_q;
  assign if_rdata  = if_rdata_q;
  assign if_err    = if_err_q;
  assign d_rdata   = d_rdata_q;
  assign d_err     = d_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: a transaction-level model predicts grant order,
// access timing and returned data from the arbitration rules; every output is checked each cycle.
module tb_mem_port_arbiter;

  localparam int unsigned DW     = 32;
  localparam int unsigned AW     = 11;
  localparam int unsigned DEPTH  = 1024;
  localparam int unsigned LAT    = 1;
  localparam int unsigned STREAK = 4;

  logic          clk1 = 1'b0;
  logic          reset_n;
  logic          if_req, if_flush, if_ack, if_err;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          d_req, d_we, d_ack, d_err;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata, d_rdata;
  logic          mem_en, mem_we, busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  always #5 clk1 = ~clk1;

  mem_port_arbiter #(
    .DW              (DW),
    .AW              (AW),
    .MEM_DEPTH       (DEPTH),
    .MEM_LAT         (LAT),
    .MAX_DATA_STREAK (STREAK)
  ) dut (
    .clk1      (clk1),
    .reset_n   (reset_n),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_flush  (if_flush),
    .if_ack    (if_ack),
    .if_rdata  (if_rdata),
    .if_err    (if_err),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_ack     (d_ack),
    .d_rdata   (d_rdata),
    .d_err     (d_err),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  function automatic logic [DW-1:0] init_word(input int unsigned a);
    return (32'(a) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Memory device: one-cycle read latency, garbage on the bus when no read is due.
  bit [DW-1:0] phys    [DEPTH];
  bit          written [DEPTH];
  always @(posedge clk1) begin
    if (mem_en && mem_we) begin
      phys[mem_addr[9:0]]    <= mem_wdata;
      written[mem_addr[9:0]] <= 1'b1;
    end
    if (mem_en && !mem_we)
      mem_rdata <= written[mem_addr[9:0]] ? phys[mem_addr[9:0]] : init_word(32'(mem_addr[9:0]));
    else
      mem_rdata <= $urandom;
  end

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  // Reference model state (transaction level).
  logic [DW-1:0] ref_mem [DEPTH];
  int unsigned   cyc, next_sample, streak;
  bit            have_txn, t_if, t_err, t_we, t_drop;
  int unsigned   t_g, t_ack;
  logic [AW-1:0] t_addr;
  logic [DW-1:0] t_wdata, t_rdata;
  logic [DW-1:0] exp_if_rdata, exp_d_rdata;
  bit            exp_if_err, exp_d_err;
  bit            e_busy, e_en, e_if_ack, e_d_ack;
  bit            if_active, d_active, d_w;
  logic [AW-1:0] if_a, d_a;
  logic [DW-1:0] d_wd;

  function automatic logic [AW-1:0] rand_addr();
    if ($urandom_range(9) == 0) return AW'(DEPTH + $urandom_range(DEPTH - 1));
    return AW'($urandom_range(DEPTH - 1));
  endfunction

  task automatic check_outputs();
    e_busy   = have_txn && cyc >= t_g && cyc <= t_ack;
    e_en     = have_txn && !t_err && cyc == t_g;
    e_if_ack = have_txn && cyc == t_ack && t_if && !t_drop;
    e_d_ack  = have_txn && cyc == t_ack && !t_if;
    if (e_if_ack) begin
      exp_if_rdata = t_rdata;
      exp_if_err   = t_err;
    end
    if (e_d_ack) begin
      exp_d_rdata = t_rdata;
      exp_d_err   = t_err;
    end
    check_eq("busy", 64'(busy), 64'(e_busy));
    check_eq("mem_en", 64'(mem_en), 64'(e_en));
    check_eq("mem_we", 64'(mem_we), 64'(e_en && t_we));
    check_eq("mem_addr", 64'(mem_addr), e_en ? 64'(t_addr) : 64'd0);
    check_eq("mem_wdata", 64'(mem_wdata), e_en ? 64'(t_wdata) : 64'd0);
    check_eq("if_ack", 64'(if_ack), 64'(e_if_ack));
    check_eq("d_ack", 64'(d_ack), 64'(e_d_ack));
    check_eq("if_rdata", 64'(if_rdata), 64'(exp_if_rdata));
    check_eq("if_err", 64'(if_err), 64'(exp_if_err));
    check_eq("d_rdata", 64'(d_rdata), 64'(exp_d_rdata));
    check_eq("d_err", 64'(d_err), 64'(exp_d_err));
  endtask

  task automatic run_cycles(input int unsigned n, input int unsigned p_if,
                            input int unsigned p_d, input bit allow_new);
    int unsigned k;
    bit gi;
    for (int unsigned i = 0; i < n; i++) begin
      @(negedge clk1);
      cyc++;
      check_outputs();
      if (e_if_ack) if_active = 1'b0;
      if (e_d_ack) d_active = 1'b0;
      // Requesters: fetch may be flushed (branch) at any time; data holds until acked.
      if_flush = 1'b0;
      if ($urandom_range(19) == 0) begin
        if_flush  = 1'b1;
        if_active = 1'b0;
      end else if (!if_active && allow_new && $urandom_range(99) < p_if) begin
        if_active = 1'b1;
        if_a      = rand_addr();
      end
      if (!d_active && allow_new && $urandom_range(99) < p_d) begin
        d_active = 1'b1;
        d_w      = ($urandom_range(2) == 0);
        d_a      = rand_addr();
        d_wd     = $urandom;
      end
      if_req  = if_active;
      if_addr = if_a;
      d_req   = d_active;
      d_we    = d_w;
      d_addr  = d_a;
      d_wdata = d_wd;
      // Model the next edge.
      k = cyc + 1;
      if (have_txn && t_if && if_flush && k >= t_g + 1 && k <= t_ack) t_drop = 1'b1;
      if (k >= next_sample && (if_req || d_req)) begin
        gi          = if_req && (!d_req || streak == STREAK);
        streak      = (!gi && if_req) ? streak + 1 : 0;
        have_txn    = 1'b1;
        t_if        = gi;
        t_g         = k;
        t_drop      = 1'b0;
        t_addr      = gi ? if_addr : d_addr;
        t_we        = !gi && d_we;
        t_wdata     = t_we ? d_wdata : '0;
        t_err       = 32'(t_addr) >= DEPTH;
        t_ack       = t_err ? k : k + LAT + 1;
        next_sample = t_ack + 2;
        if (t_err || t_we) t_rdata = '0;
        else t_rdata = ref_mem[t_addr[9:0]];
        if (t_we && !t_err) ref_mem[t_addr[9:0]] = t_wdata;
      end
    end
  endtask

  initial begin
    for (int unsigned a = 0; a < DEPTH; a++) ref_mem[a] = init_word(a);
    reset_n  = 1'b0;
    if_req   = 1'b0;
    if_addr  = '0;
    if_flush = 1'b0;
    d_req    = 1'b0;
    d_we     = 1'b0;
    d_addr   = '0;
    d_wdata  = '0;
    have_txn = 1'b0;
    t_if = 1'b0; t_err = 1'b0; t_we = 1'b0; t_drop = 1'b0;
    t_g = 0; t_ack = 0; t_addr = '0; t_wdata = '0; t_rdata = '0;
    exp_if_rdata = '0; exp_d_rdata = '0; exp_if_err = 1'b0; exp_d_err = 1'b0;
    if_active = 1'b0; d_active = 1'b0; d_w = 1'b0;
    if_a = '0; d_a = '0; d_wd = '0;
    streak = 0; next_sample = 0; cyc = 0;
    repeat (3) @(posedge clk1);
    @(negedge clk1);
    check_outputs();
    reset_n = 1'b1;

    run_cycles(1500, 30, 30, 1'b1);
    run_cycles(1500, 100, 100, 1'b1);
    run_cycles(20, 0, 0, 1'b0);

    // Reset in the middle of a load: outputs clear immediately and no ack follows.
    @(negedge clk1);
    if_req   = 1'b0;
    if_flush = 1'b0;
    d_req    = 1'b1;
    d_we     = 1'b0;
    d_addr   = 11'd3;
    @(negedge clk1);
    check_eq("rst_pre_issue", 64'(mem_en), 64'd1);
    @(posedge clk1);
    #2;
    reset_n = 1'b0;
    #1;
    have_txn     = 1'b0;
    exp_if_rdata = '0;
    exp_d_rdata  = '0;
    exp_if_err   = 1'b0;
    exp_d_err    = 1'b0;
    check_outputs();
    d_req = 1'b0;
    @(negedge clk1);
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk1);
      check_eq("rst_no_dack", 64'(d_ack), 64'd0);
      check_eq("rst_idle", 64'(busy), 64'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
